// File: rtl/lstm_ctrl_pkg.sv
// rtl/lstm_ctrl_pkg.sv - shared state encoding and fixed-point defaults for the LSTM sequencer
// Purpose: FSM state enum, default data/fraction widths, Q-format unit constant.
// Ports: none (package).
package lstm_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT_X = 3'd1,
    ST_SETTLE = 3'd2,
    ST_EMIT   = 3'd3,
    ST_FIN    = 3'd4
  } lstm_state_e;

  localparam int LSTM_DATA_WIDTH  = 16;
  localparam int LSTM_FRACT_WIDTH = 8;

  // 1.0 in Q(LSTM_DATA_WIDTH-LSTM_FRACT_WIDTH).LSTM_FRACT_WIDTH
  localparam logic [LSTM_DATA_WIDTH-1:0] LSTM_Q_ONE = LSTM_DATA_WIDTH'(1) <<< LSTM_FRACT_WIDTH;

endpackage

// File: rtl/lstm_settle_timer.sv
// rtl/lstm_settle_timer.sv - loadable down-counter timing the cell settle window
// Purpose: load SETTLE_CYCLES-1 on load, count down on dec, flag zero.
// Ports: clk, rst (sync, active-high), load, dec in; zero out.
module lstm_settle_timer #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CW            = $clog2(SETTLE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic zero
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CW'(SETTLE_CYCLES - 1);
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/lstm_seq_ctrl.sv
// rtl/lstm_seq_ctrl.sv - sequencer running a combinational LSTM cell over SEQ timesteps
// Purpose: owns recurrent c/h registers, feeds the cell, waits a settle window,
//   captures c_t/h_t and streams h_t out with a valid/ready handshake.
// Ports: clk, rst; start/seq_len/c_init/h_init (sequence setup); abort;
//   x_valid/x_data/x_ready (input stream); cell_x/cell_c_in/cell_h_in (to cell);
//   cell_c_out/cell_h_out (from cell); h_valid/h_data/h_ready (output stream);
//   step_idx, busy, done (status).
module lstm_seq_ctrl
  import lstm_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH    = LSTM_DATA_WIDTH,
  parameter int FRACT_WIDTH   = LSTM_FRACT_WIDTH,
  parameter int LEN_W         = 8,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_W-1:0]      seq_len,
  input  logic [DATA_WIDTH-1:0] c_init,
  input  logic [DATA_WIDTH-1:0] h_init,
  input  logic                  abort,
  input  logic                  x_valid,
  input  logic [DATA_WIDTH-1:0] x_data,
  output logic                  x_ready,
  output logic [DATA_WIDTH-1:0] cell_x,
  output logic [DATA_WIDTH-1:0] cell_c_in,
  output logic [DATA_WIDTH-1:0] cell_h_in,
  input  logic [DATA_WIDTH-1:0] cell_c_out,
  input  logic [DATA_WIDTH-1:0] cell_h_out,
  output logic                  h_valid,
  output logic [DATA_WIDTH-1:0] h_data,
  input  logic                  h_ready,
  output logic [LEN_W-1:0]      step_idx,
  output logic                  busy,
  output logic                  done
);

  if (SETTLE_CYCLES < 1 || FRACT_WIDTH >= DATA_WIDTH) begin : g_param_check
    $error("lstm_seq_ctrl: need SETTLE_CYCLES >= 1 and FRACT_WIDTH < DATA_WIDTH");
  end

  lstm_state_e           state_q, state_d;
  logic [LEN_W-1:0]      seq_len_q, seq_len_d;
  logic [LEN_W-1:0]      step_q, step_d;
  logic [DATA_WIDTH-1:0] c_q, c_d;
  logic [DATA_WIDTH-1:0] h_q, h_d;
  logic [DATA_WIDTH-1:0] x_q, x_d;
  logic [DATA_WIDTH-1:0] h_data_q, h_data_d;

  logic tmr_load, tmr_dec, tmr_zero;

  lstm_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle_timer (
    .clk  (clk),
    .rst  (rst),
    .load (tmr_load),
    .dec  (tmr_dec),
    .zero (tmr_zero)
  );

  always_comb begin
    state_d   = state_q;
    seq_len_d = seq_len_q;
    step_d    = step_q;
    c_d       = c_q;
    h_d       = h_q;
    x_d       = x_q;
    h_data_d  = h_data_q;
    tmr_load  = 1'b0;
    tmr_dec   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          seq_len_d = seq_len;
          c_d       = c_init;
          h_d       = h_init;
          step_d    = '0;
          state_d   = (seq_len == '0) ? ST_FIN : ST_WAIT_X;
        end
      end
      ST_WAIT_X: begin
        if (x_valid) begin
          x_d      = x_data;
          tmr_load = 1'b1;
          state_d  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (tmr_zero) begin
          c_d      = cell_c_out;
          h_d      = cell_h_out;
          h_data_d = cell_h_out;
          state_d  = ST_EMIT;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_EMIT: begin
        if (h_ready) begin
          if (step_q == seq_len_q - LEN_W'(1)) begin
            state_d = ST_FIN;
          end else begin
            step_d  = step_q + LEN_W'(1);
            state_d = ST_WAIT_X;
          end
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // abort overrides everything: drop any capture or step advance in this cycle
    if (abort && (state_q != ST_IDLE)) begin
      state_d  = ST_IDLE;
      step_d   = step_q;
      c_d      = c_q;
      h_d      = h_q;
      x_d      = x_q;
      h_data_d = h_data_q;
      tmr_load = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      seq_len_q <= '0;
      step_q    <= '0;
      c_q       <= '0;
      h_q       <= '0;
      x_q       <= '0;
      h_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      seq_len_q <= seq_len_d;
      step_q    <= step_d;
      c_q       <= c_d;
      h_q       <= h_d;
      x_q       <= x_d;
      h_data_q  <= h_data_d;
    end
  end

  // status/handshake outputs decode the registered state only
  assign x_ready   = (state_q == ST_WAIT_X);
  assign h_valid   = (state_q == ST_EMIT);
  assign done      = (state_q == ST_FIN);
  assign busy      = (state_q != ST_IDLE);
  assign cell_x    = x_q;
  assign cell_c_in = c_q;
  assign cell_h_in = h_q;
  assign h_data    = h_data_q;
  assign step_idx  = step_q;

endmodule

// File: tb/tb_lstm_seq_ctrl.sv
// tb/tb_lstm_seq_ctrl.sv - self-checking bench for lstm_seq_ctrl with a stub cell
module tb_lstm_seq_ctrl;
  import lstm_ctrl_pkg::*;

  localparam int S = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  seq_len = '0;
  logic [15:0] c_init = '0, h_init = '0;
  logic        abort = 1'b0;
  logic        x_valid = 1'b0;
  logic [15:0] x_data = '0;
  logic        x_ready;
  logic [15:0] cell_x, cell_c_in, cell_h_in, cell_c_out, cell_h_out;
  logic        h_valid;
  logic [15:0] h_data;
  logic        h_ready = 1'b0;
  logic [7:0]  step_idx;
  logic        busy, done;

  always #5 clk = ~clk;

  // stub cell
  assign cell_c_out = cell_c_in + cell_x;
  assign cell_h_out = cell_x;

  lstm_seq_ctrl #(.DATA_WIDTH(16), .FRACT_WIDTH(8), .LEN_W(8), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .start(start), .seq_len(seq_len), .c_init(c_init), .h_init(h_init),
    .abort(abort), .x_valid(x_valid), .x_data(x_data), .x_ready(x_ready),
    .cell_x(cell_x), .cell_c_in(cell_c_in), .cell_h_in(cell_h_in),
    .cell_c_out(cell_c_out), .cell_h_out(cell_h_out),
    .h_valid(h_valid), .h_data(h_data), .h_ready(h_ready),
    .step_idx(step_idx), .busy(busy), .done(done)
  );

  int pass_cnt = 0;
  int chk_cnt  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // ---------------- behavioural reference model ----------------
  // Evaluated at negedge: compares outputs, then applies the effect of the
  // inputs that the coming rising edge will sample.
  bit          mon_en = 0;
  bit          m_act = 0, m_wx = 0, m_emit = 0, m_fin = 0;
  int          m_cap = -1;
  int          ncyc = 0;
  logic [15:0] m_c = '0, m_h = '0, m_x = '0, m_hd = '0;
  logic [7:0]  m_step = '0, m_len = '0;

  initial begin
    wait (mon_en);
    forever begin
      @(negedge clk);
      chk("busy", busy, m_act);
      chk("x_ready", x_ready, m_wx);
      chk("h_valid", h_valid, m_emit);
      chk("done", done, m_fin);
      chk("cell_c_in", cell_c_in, m_c);
      chk("cell_h_in", cell_h_in, m_h);
      chk("cell_x", cell_x, m_x);
      chk("h_data", h_data, m_hd);
      chk("step_idx", step_idx, m_step);
      if (rst) begin
        m_act = 0; m_wx = 0; m_emit = 0; m_fin = 0; m_cap = -1;
        m_c = '0; m_h = '0; m_x = '0; m_hd = '0; m_step = '0; m_len = '0;
      end else if (abort && m_act) begin
        m_act = 0; m_wx = 0; m_emit = 0; m_fin = 0; m_cap = -1;
      end else if (m_fin) begin
        m_fin = 0; m_act = 0;
      end else if (!m_act) begin
        if (start) begin
          m_len = seq_len; m_c = c_init; m_h = h_init; m_step = '0; m_act = 1;
          if (seq_len == 0) m_fin = 1; else m_wx = 1;
        end
      end else if (m_wx) begin
        if (x_valid) begin
          m_x = x_data; m_wx = 0; m_cap = ncyc + S;
        end
      end else if (m_cap == ncyc) begin
        m_c = m_c + m_x; m_h = m_x; m_hd = m_x; m_emit = 1; m_cap = -1;
      end else if (m_emit && h_ready) begin
        m_emit = 0;
        if (int'(m_step) == int'(m_len) - 1) m_fin = 1;
        else begin m_step = m_step + 8'd1; m_wx = 1; end
      end
      ncyc++;
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [15:0] xs_tab [16];
  logic [15:0] got_h [$];
  int          kx = 0, ndone = 0, nxr = 0;
  bit          aborted = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    if (x_valid && x_ready) kx++;
    if (x_ready) nxr++;
    if (h_valid && h_ready) got_h.push_back(h_data);
    if (done) ndone++;
    tick();
    x_data = xs_tab[kx];
  endtask

  task automatic start_seq(input int len, input logic [15:0] c0, input logic [15:0] h0);
    kx = 0; ndone = 0; nxr = 0; aborted = 0; got_h.delete();
    x_data = xs_tab[0];
    seq_len = 8'(len); c_init = c0; h_init = h0; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic drive(input int xvp, input int hrp, input int apct);
    for (int i = 0; i < 300 && busy; i++) begin
      x_valid = ($urandom_range(0, 99) < xvp);
      h_ready = ($urandom_range(0, 99) < hrp);
      abort   = (apct > 0) && ($urandom_range(0, 99) < apct);
      if (abort) aborted = 1;
      cyc();
    end
    x_valid = 1'b0; h_ready = 1'b0; abort = 1'b0;
    chk("seq_end_idle", busy, 1'b0);
  endtask

  task automatic check_run(input string nm, input int n, input logic [15:0] c_exp);
    chk({nm, " done_cnt"}, ndone, 1);
    chk({nm, " h_count"}, got_h.size(), n);
    for (int i = 0; i < n && i < got_h.size(); i++) chk({nm, " h_seq"}, got_h[i], xs_tab[i]);
    chk({nm, " c_final"}, cell_c_in, c_exp);
  endtask

  task automatic wait_hvalid(input string nm);
    for (int i = 0; i < 30 && !h_valid; i++) cyc();
    chk({nm, " h_valid_seen"}, h_valid, 1'b1);
  endtask

  initial begin
    logic [15:0] esum;
    int len;
    for (int i = 0; i < 16; i++) xs_tab[i] = '0;
    tick(); tick();
    // reset state
    chk("rst busy", busy, 0);
    chk("rst x_ready", x_ready, 0);
    chk("rst h_valid", h_valid, 0);
    chk("rst done", done, 0);
    chk("rst c", cell_c_in, 0);
    chk("rst step", step_idx, 0);
    mon_en = 1;
    rst = 1'b0;
    tick();

    // 3-step run, full throughput
    xs_tab[0] = 16'h0010; xs_tab[1] = 16'h0020; xs_tab[2] = 16'h0030;
    start_seq(3, 16'h0100, 16'h0000);
    drive(100, 100, 0);
    check_run("s3", 3, 16'h0160);
    chk("s3 h_last", cell_h_in, 16'h0030);
    chk("s3 step_final", step_idx, 8'd2);
    tick();

    // h_ready backpressure
    start_seq(2, 16'h0100, 16'h0000);
    x_valid = 1'b1; h_ready = 1'b0;
    wait_hvalid("bp");
    for (int i = 0; i < 5; i++) begin
      chk("bp h_data", h_data, 16'h0010);
      chk("bp x_ready", x_ready, 1'b0);
      chk("bp step", step_idx, 8'd0);
      cyc();
    end
    drive(100, 100, 0);
    check_run("bp", 2, 16'h0130);

    // seq_len == 0
    start_seq(0, 16'h1234, 16'h0055);
    chk("len0 done_next", done, 1'b1);
    drive(100, 100, 0);
    chk("len0 done_cnt", ndone, 1);
    chk("len0 no_xready", nxr, 0);
    chk("len0 c", cell_c_in, 16'h1234);
    chk("len0 h", cell_h_in, 16'h0055);

    // abort in SETTLE of step 1
    xs_tab[0] = 16'h0010; xs_tab[1] = 16'h0020; xs_tab[2] = 16'h0030; xs_tab[3] = 16'h0040;
    start_seq(4, 16'h0100, 16'h0000);
    x_valid = 1'b1; h_ready = 1'b1;
    for (int i = 0; i < 40 && kx < 2; i++) cyc();
    x_valid = 1'b0;
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("ab busy", busy, 1'b0);
    chk("ab c", cell_c_in, 16'h0110);
    chk("ab h", cell_h_in, 16'h0010);
    for (int i = 0; i < 4; i++) cyc();
    chk("ab done_cnt", ndone, 0);
    chk("ab h_count", got_h.size(), 1);

    // start while busy is ignored
    xs_tab[0] = 16'h0010; xs_tab[1] = 16'h0020; xs_tab[2] = 16'h0030;
    start_seq(3, 16'h0100, 16'h0000);
    x_valid = 1'b1; h_ready = 1'b1;
    cyc(); cyc();
    start = 1'b1; seq_len = 8'd7; c_init = 16'hFFFF;
    cyc();
    start = 1'b0;
    drive(100, 100, 0);
    check_run("ign", 3, 16'h0160);

    // rst in EMIT
    start_seq(3, 16'h0100, 16'h0000);
    x_valid = 1'b1; h_ready = 1'b0;
    wait_hvalid("rs");
    rst = 1'b1;
    tick();
    rst = 1'b0; x_valid = 1'b0;
    chk("rs busy", busy, 0);
    chk("rs h_valid", h_valid, 0);
    chk("rs x_ready", x_ready, 0);
    chk("rs h_data", h_data, 0);
    chk("rs c", cell_c_in, 0);
    chk("rs h", cell_h_in, 0);
    chk("rs x", cell_x, 0);
    chk("rs step", step_idx, 0);
    xs_tab[0] = 16'h0005; xs_tab[1] = 16'h0006;
    start_seq(2, 16'h0200, 16'h0007);
    drive(100, 100, 0);
    check_run("rs", 2, 16'h020B);

    // randomized sequences
    for (int r = 0; r < 25; r++) begin
      len = $urandom_range(0, 6);
      esum = 16'($urandom);
      for (int i = 0; i < 16; i++) xs_tab[i] = 16'($urandom);
      c_init = esum;
      start_seq(len, esum, 16'($urandom));
      for (int i = 0; i < len; i++) esum = esum + xs_tab[i];
      drive($urandom_range(30, 100), $urandom_range(30, 100), (r % 4 == 3) ? 4 : 0);
      if (!aborted) check_run("rnd", len, esum);
      tick();
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
